// File: rtl/servo_return_pkg.sv
// Shared types and default constants for the servo return path.
// Also used by the PWM generator and the max-value register array.
package servo_return_pkg;

    localparam int PW_W  = 32;
    localparam int ADC_W = 12;

    localparam int unsigned     FRAME_CYCLES_DEF  = 2000000;
    localparam int unsigned     STEP_DEF          = 1000;
    localparam int unsigned     SETTLE_FRAMES_DEF = 5;
    localparam logic [PW_W-1:0] PW_INIT_DEF       = 32'd150000;
    localparam logic [PW_W-1:0] PW_MIN_DEF        = 32'd50000;
    localparam logic [PW_W-1:0] PW_MAX_DEF        = 32'd250000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] val,
                                                 input logic [PW_W-1:0] lo,
                                                 input logic [PW_W-1:0] hi);
        logic [PW_W-1:0] res;
        res = val;
        if (val < lo) res = lo;
        if (val > hi) res = hi;
        return res;
    endfunction

endpackage

// File: rtl/servo_return_if.sv
// Command/target/setpoint bundle between the tracking controller (master)
// and servo_return (slave).
interface servo_return_if;
    import servo_return_pkg::*;

    logic              go;
    logic [PW_W-1:0]   pw_max_h;
    logic [PW_W-1:0]   pw_max_v;
    logic [ADC_W-1:0]  lv;
    logic [PW_W-1:0]   pw_out_h;
    logic [PW_W-1:0]   pw_out_v;
    logic [ADC_W-1:0]  lv_held;
    logic              busy;
    logic              done;
    logic              novalid;

    modport master (
        output go, pw_max_h, pw_max_v, lv,
        input  pw_out_h, pw_out_v, lv_held, busy, done, novalid
    );

    modport slave (
        input  go, pw_max_h, pw_max_v, lv,
        output pw_out_h, pw_out_v, lv_held, busy, done, novalid
    );

endinterface

// File: rtl/servo_slew_axis.sv
// One servo axis: target register plus a setpoint that walks toward it by at
// most STEP per enabled tick, never overshooting.
module servo_slew_axis
    import servo_return_pkg::*;
#(
    parameter int unsigned     STEP    = STEP_DEF,
    parameter logic [PW_W-1:0] PW_INIT = PW_INIT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PW_W-1:0] load_val,
    input  logic            step_en,
    output logic [PW_W-1:0] cur,
    output logic            at_tgt_next
);

    localparam logic [PW_W-1:0] STEP_W = PW_W'(STEP);

    logic [PW_W-1:0] cur_q, cur_d;
    logic [PW_W-1:0] tgt_q, tgt_d;
    logic [PW_W-1:0] gap;

    // Distance is always larger-minus-smaller, so the move cannot wrap.
    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        gap   = '0;
        if (load) begin
            tgt_d = load_val;
        end
        if (step_en) begin
            if (cur_q < tgt_q) begin
                gap   = tgt_q - cur_q;
                cur_d = cur_q + ((gap < STEP_W) ? gap : STEP_W);
            end else if (cur_q > tgt_q) begin
                gap   = cur_q - tgt_q;
                cur_d = cur_q - ((gap < STEP_W) ? gap : STEP_W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q <= PW_INIT;
            tgt_q <= PW_INIT;
        end else begin
            cur_q <= cur_d;
            tgt_q <= tgt_d;
        end
    end

    assign cur         = cur_q;
    assign at_tgt_next = (cur_d == tgt_q);

endmodule

// File: rtl/servo_return.sv
// Slews both servo setpoints to the stored best position, one step per frame.
// Optional macro SERVO_RETURN_CLAMP_EN clamps captured targets to [PW_MIN, PW_MAX].
module servo_return
    import servo_return_pkg::*;
#(
    parameter int unsigned     FRAME_CYCLES  = FRAME_CYCLES_DEF,
    parameter int unsigned     STEP          = STEP_DEF,
    parameter int unsigned     SETTLE_FRAMES = SETTLE_FRAMES_DEF,
`ifdef SERVO_RETURN_CLAMP_EN
    parameter logic [PW_W-1:0] PW_MIN        = PW_MIN_DEF,
    parameter logic [PW_W-1:0] PW_MAX        = PW_MAX_DEF,
`endif
    parameter logic [PW_W-1:0] PW_INIT       = PW_INIT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    servo_return_if.slave  bus
);

    localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_FRAMES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [ADC_W-1:0]  lv_held_q, lv_held_d;
    logic              done_q, done_d;
    logic              novalid_q, novalid_d;

    logic              ftick;
    logic              empty_tgt;
    logic              go_ok;
    logic              load;
    logic              step_en;
    logic              h_at_next, v_at_next;
    logic [PW_W-1:0]   tgt_h_in, tgt_v_in;

    assign ftick     = (cnt_q == CNT_LAST);
    assign cnt_d     = ftick ? '0 : cnt_q + 1'b1;
    assign empty_tgt = (bus.pw_max_h == '0) && (bus.pw_max_v == '0);
    assign go_ok     = bus.go && !empty_tgt;

    // Empty-target detection above looks at raw inputs, before any clamp.
`ifdef SERVO_RETURN_CLAMP_EN
    assign tgt_h_in = clamp_pw(bus.pw_max_h, PW_MIN, PW_MAX);
    assign tgt_v_in = clamp_pw(bus.pw_max_v, PW_MIN, PW_MAX);
`else
    assign tgt_h_in = bus.pw_max_h;
    assign tgt_v_in = bus.pw_max_v;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            settle_q  <= '0;
            lv_held_q <= '0;
            done_q    <= 1'b0;
            novalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            lv_held_q <= lv_held_d;
            done_q    <= done_d;
            novalid_q <= novalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            IDLE: begin
                if (go_ok) state_d = SLEW;
            end
            SLEW: begin
                if (ftick && h_at_next && v_at_next) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
            end
            SETTLE: begin
                if (ftick) begin
                    if (settle_q == SETTLE_LAST) state_d = IDLE;
                    else                         settle_d = settle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load      = (state_q == IDLE) && go_ok;
        step_en   = (state_q == SLEW) && ftick;
        done_d    = (state_q == SETTLE) && ftick && (settle_q == SETTLE_LAST);
        novalid_d = (state_q == IDLE) && bus.go && empty_tgt;
        lv_held_d = load ? bus.lv : lv_held_q;
    end

    servo_slew_axis #(.STEP(STEP), .PW_INIT(PW_INIT)) u_axis_h (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (tgt_h_in),
        .step_en     (step_en),
        .cur         (bus.pw_out_h),
        .at_tgt_next (h_at_next)
    );

    servo_slew_axis #(.STEP(STEP), .PW_INIT(PW_INIT)) u_axis_v (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .load_val    (tgt_v_in),
        .step_en     (step_en),
        .cur         (bus.pw_out_v),
        .at_tgt_next (v_at_next)
    );

    assign bus.lv_held = lv_held_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.novalid = novalid_q;

endmodule

// File: tb/tb_servo_return.sv
// Bench for servo_return: directed scenarios with literal expectations plus
// random GO/reset traffic checked every cycle against a behavioural model.
module tb_servo_return;

    localparam int          FRAME_CYCLES  = 10;
    localparam logic [31:0] STEP          = 32'd100;
    localparam logic [31:0] PW_INIT       = 32'd1500;
    localparam int          SETTLE_FRAMES = 2;
    localparam logic [31:0] PW_MIN        = 32'd500;
    localparam logic [31:0] PW_MAX        = 32'd2500;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   check_en;

    servo_return_if bus ();

    servo_return #(
        .FRAME_CYCLES  (FRAME_CYCLES),
        .STEP          (STEP),
        .SETTLE_FRAMES (SETTLE_FRAMES),
`ifdef SERVO_RETURN_CLAMP_EN
        .PW_MIN        (PW_MIN),
        .PW_MAX        (PW_MAX),
`endif
        .PW_INIT       (PW_INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Behavioural model: spec rules in plain arithmetic, updated on each rising edge.
    logic [31:0] m_h, m_v, m_tgt_h, m_tgt_v;
    logic [11:0] m_lv;
    int          m_cnt, m_settle, m_mode;
    bit          m_done, m_nov, m_tick;

    function automatic logic [31:0] approach(input logic [31:0] cur, input logic [31:0] tgt);
        if (cur < tgt) return (tgt - cur > STEP) ? cur + STEP : tgt;
        if (cur > tgt) return (cur - tgt > STEP) ? cur - STEP : tgt;
        return cur;
    endfunction

    function automatic logic [31:0] limitTarget(input logic [31:0] t);
`ifdef SERVO_RETURN_CLAMP_EN
        if (t < PW_MIN) return PW_MIN;
        if (t > PW_MAX) return PW_MAX;
`endif
        return t;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0; m_h = PW_INIT; m_v = PW_INIT; m_tgt_h = PW_INIT; m_tgt_v = PW_INIT;
            m_lv = '0; m_mode = 0; m_settle = 0; m_done = 0; m_nov = 0;
        end else begin
            m_tick = (m_cnt == FRAME_CYCLES - 1);
            m_cnt  = m_tick ? 0 : m_cnt + 1;
            m_done = 0;
            m_nov  = 0;
            if (m_mode == 0) begin
                if (bus.go) begin
                    if (bus.pw_max_h == 0 && bus.pw_max_v == 0) begin
                        m_nov = 1;
                    end else begin
                        m_tgt_h = limitTarget(bus.pw_max_h);
                        m_tgt_v = limitTarget(bus.pw_max_v);
                        m_lv    = bus.lv;
                        m_mode  = 1;
                    end
                end
            end else if (m_mode == 1) begin
                if (m_tick) begin
                    m_h = approach(m_h, m_tgt_h);
                    m_v = approach(m_v, m_tgt_v);
                    if (m_h == m_tgt_h && m_v == m_tgt_v) begin
                        m_mode   = 2;
                        m_settle = SETTLE_FRAMES;
                    end
                end
            end else if (m_tick) begin
                m_settle--;
                if (m_settle == 0) begin
                    m_done = 1;
                    m_mode = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_pw_out_h", bus.pw_out_h, m_h);
            checkOutput("cyc_pw_out_v", bus.pw_out_v, m_v);
            checkOutput("cyc_lv_held", 32'(bus.lv_held), 32'(m_lv));
            checkOutput("cyc_busy", 32'(bus.busy), 32'(m_mode != 0));
            checkOutput("cyc_done", 32'(bus.done), 32'(m_done));
            checkOutput("cyc_novalid", 32'(bus.novalid), 32'(m_nov));
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One-cycle GO pulse; returns at the falling edge of the cycle after acceptance.
    task automatic applyStimulus(input logic [31:0] h, input logic [31:0] v, input logic [11:0] l);
        @(negedge clk);
        bus.go = 1'b1;
        bus.pw_max_h = h;
        bus.pw_max_v = v;
        bus.lv = l;
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic waitDone(input int max_cyc, output bit seen, output int h_changes);
        logic [31:0] last_h;
        seen = 0;
        h_changes = 0;
        last_h = bus.pw_out_h;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (bus.pw_out_h != last_h) h_changes++;
            last_h = bus.pw_out_h;
            if (bus.done) seen = 1;
        end
    endtask

    initial begin
        logic [31:0] h_q[$];
        logic [31:0] v_q[$];
        logic [31:0] last_h, last_v;
        int          h_done_at, done_at, hc, dcount;
        bit          seen;

        total = 0; bad = 0; check_en = 0;
        rst_n = 1'b0;
        bus.go = 1'b0; bus.pw_max_h = '0; bus.pw_max_v = '0; bus.lv = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_en = 1;

        checkOutput("rst_pw_out_h", bus.pw_out_h, 32'd1500);
        checkOutput("rst_pw_out_v", bus.pw_out_v, 32'd1500);
        checkOutput("rst_lv_held", 32'(bus.lv_held), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done_novalid", 32'({bus.done, bus.novalid}), 32'd0);

        // Empty targets are rejected with a single NOVALID pulse.
        applyStimulus(32'd0, 32'd0, 12'h055);
        checkOutput("s2_novalid", 32'(bus.novalid), 32'd1);
        checkOutput("s2_busy", 32'(bus.busy), 32'd0);
        checkOutput("s2_pw_out_h", bus.pw_out_h, 32'd1500);
        @(negedge clk);
        checkOutput("s2_novalid_drop", 32'(bus.novalid), 32'd0);

        // Main move, with a second GO while busy that must be ignored.
        applyStimulus(32'd1750, 32'd1300, 12'h7A3);
        checkOutput("s1_busy", 32'(bus.busy), 32'd1);
        checkOutput("s1_lv_held", 32'(bus.lv_held), 32'h7A3);
        last_h = bus.pw_out_h; last_v = bus.pw_out_v;
        seen = 0; h_done_at = -1; done_at = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            bus.go       = (i == 3);
            bus.pw_max_h = (i == 3) ? 32'd2000 : 32'd1750;
            bus.lv       = (i == 3) ? 12'h111 : 12'h7A3;
            @(negedge clk);
            if (bus.pw_out_h != last_h) begin
                h_q.push_back(bus.pw_out_h);
                if (bus.pw_out_h == 32'd1750) h_done_at = i;
            end
            if (bus.pw_out_v != last_v) v_q.push_back(bus.pw_out_v);
            last_h = bus.pw_out_h; last_v = bus.pw_out_v;
            if (bus.done) begin
                seen = 1;
                done_at = i;
                checkOutput("s1_busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
        bus.go = 1'b0;
        checkOutput("s1_done_seen", 32'(seen), 32'd1);
        checkOutput("s1_h_steps", 32'(h_q.size()), 32'd3);
        checkOutput("s1_h0", (h_q.size() > 0) ? h_q[0] : 32'd0, 32'd1600);
        checkOutput("s1_h1", (h_q.size() > 1) ? h_q[1] : 32'd0, 32'd1700);
        checkOutput("s1_h2", (h_q.size() > 2) ? h_q[2] : 32'd0, 32'd1750);
        checkOutput("s1_v_steps", 32'(v_q.size()), 32'd2);
        checkOutput("s1_v0", (v_q.size() > 0) ? v_q[0] : 32'd0, 32'd1400);
        checkOutput("s1_v1", (v_q.size() > 1) ? v_q[1] : 32'd0, 32'd1300);
        checkOutput("s1_done_delay", 32'(done_at - h_done_at), 32'(2 * FRAME_CYCLES));
        checkOutput("s3_final_h", bus.pw_out_h, 32'd1750);
        checkOutput("s3_lv_kept", 32'(bus.lv_held), 32'h7A3);

        // Targets equal to current setpoints: no movement, DONE after settling.
        doReset();
        applyStimulus(32'd1500, 32'd1500, 12'h001);
        waitDone(100, seen, hc);
        checkOutput("s4_done_seen", 32'(seen), 32'd1);
        checkOutput("s4_no_change", 32'(hc), 32'd0);
        checkOutput("s4_pw_out_v", bus.pw_out_v, 32'd1500);

        // Reset mid-slew abandons the move.
        doReset();
        applyStimulus(32'd1750, 32'd1300, 12'h7A3);
        for (int i = 0; i < 50 && bus.pw_out_h != 32'd1600; i++) @(negedge clk);
        checkOutput("s5_reached_1600", bus.pw_out_h, 32'd1600);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("s5_h", bus.pw_out_h, 32'd1500);
        checkOutput("s5_v", bus.pw_out_v, 32'd1500);
        checkOutput("s5_busy", 32'(bus.busy), 32'd0);
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        checkOutput("s5_no_done", 32'(dcount), 32'd0);

        // Out-of-range targets.
        doReset();
        applyStimulus(32'd3000, 32'd200, 12'h3C3);
        waitDone(400, seen, hc);
        checkOutput("s6_done_seen", 32'(seen), 32'd1);
`ifdef SERVO_RETURN_CLAMP_EN
        checkOutput("s6_h", bus.pw_out_h, 32'd2500);
        checkOutput("s6_v", bus.pw_out_v, 32'd500);
`else
        checkOutput("s6_h", bus.pw_out_h, 32'd3000);
        checkOutput("s6_v", bus.pw_out_v, 32'd200);
`endif

        // Random GO traffic, occasional empty targets and resets.
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                doReset();
            end else if ($urandom_range(0, 9) == 0) begin
                applyStimulus(32'd0, 32'd0, 12'($urandom));
            end else begin
                applyStimulus(($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(0, 3200)),
                              32'($urandom_range(0, 3200)), 12'($urandom));
            end
            bus.pw_max_h = 32'($urandom_range(0, 4000));
            bus.pw_max_v = 32'($urandom_range(0, 4000));
            bus.lv = 12'($urandom);
        end
        for (int i = 0; i < 1000 && bus.busy; i++) @(negedge clk);
        checkOutput("rand_idle_at_end", 32'(bus.busy), 32'd0);

        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
